// File: rtl/gpu_rect_pkg.sv
// Shared types and lane-mask helpers for the rectangle rasteriser.
// Lane masks are built at MAX_PPW width and sliced to PIX_PER_WORD by the user.
package gpu_rect_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_e;
  typedef enum logic {RECT_FILL, RECT_OUTLINE} rect_mode_e;
  typedef logic [11:0] coord_t;

  // Upper bound on PIX_PER_WORD (must stay strictly below this).
  localparam int MAX_PPW = 64;

  function automatic logic [MAX_PPW-1:0] lane_mask(coord_t col, coord_t min_x,
                                                   coord_t max_x, int ppw);
    int px;
    lane_mask = '0;
    for (int i = 0; i < MAX_PPW; i++) begin
      px = int'(col) * ppw + i;
      if (i < ppw && px >= int'(min_x) && px <= int'(max_x)) lane_mask[i] = 1'b1;
    end
  endfunction

  // Only the lanes holding the left or right border pixel.
  function automatic logic [MAX_PPW-1:0] edge_mask(coord_t col, coord_t min_x,
                                                   coord_t max_x, int ppw);
    int px;
    edge_mask = '0;
    for (int i = 0; i < MAX_PPW; i++) begin
      px = int'(col) * ppw + i;
      if (i < ppw && (px == int'(min_x) || px == int'(max_x))) edge_mask[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/gpu_rect_span_gen.sv
// Walks (row, word column) over a rectangle and presents registered write beats.
// Outline walking only exists when GPU_RECT_OUTLINE_EN is defined.
module gpu_rect_span_gen
  import gpu_rect_pkg::*;
#(
  parameter int FRAME_WIDTH_SCALED = 640,
  parameter int COLOR_WIDTH        = 8,
  parameter int PIX_PER_WORD       = 4,
  parameter int FBUF_ADDR_WIDTH    = 17,
  parameter int FBUF_DATA_WIDTH    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       outline,
  input  coord_t                     min_x,
  input  coord_t                     max_x,
  input  coord_t                     min_y,
  input  coord_t                     max_y,
  input  logic [COLOR_WIDTH-1:0]     color,
  input  logic                       ready,
  output logic                       en_wr,
  output logic [PIX_PER_WORD-1:0]    wrea,
  output logic [FBUF_ADDR_WIDTH-1:0] addr,
  output logic [FBUF_DATA_WIDTH-1:0] data,
  output logic                       last_accept
);

  localparam int LANE_BITS = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 0;
  localparam logic [FBUF_ADDR_WIDTH-1:0] STRIDE =
    FBUF_ADDR_WIDTH'(FRAME_WIDTH_SCALED / PIX_PER_WORD);

  coord_t row, col, cmin_q, cmax_q, min_x_q, max_x_q, max_y_q;
  coord_t row_n, col_n, cmin_ld, cmax_ld;
  logic   last, inner, inner_n;
  logic [MAX_PPW-1:0] mask_ld_w, mask_n_w;
  logic unused_mask_hi;

  function automatic logic [FBUF_ADDR_WIDTH-1:0] word_addr(coord_t r, coord_t c);
    return FBUF_ADDR_WIDTH'(r) * STRIDE + FBUF_ADDR_WIDTH'(c);
  endfunction

  assign cmin_ld = min_x >> LANE_BITS;
  assign cmax_ld = max_x >> LANE_BITS;
  assign unused_mask_hi = ^{mask_ld_w[MAX_PPW-1:PIX_PER_WORD],
                            mask_n_w[MAX_PPW-1:PIX_PER_WORD]};

`ifdef GPU_RECT_OUTLINE_EN
  rect_mode_e mode_q;
  coord_t     min_y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= RECT_FILL;
      min_y_q <= '0;
    end else if (load) begin
      mode_q  <= rect_mode_e'(outline);
      min_y_q <= min_y;
    end
  end

  assign inner   = (mode_q == RECT_OUTLINE) && (row != min_y_q) && (row != max_y_q);
  assign inner_n = (mode_q == RECT_OUTLINE) && (row_n != min_y_q) && (row_n != max_y_q);
`else
  logic unused_outline;
  assign unused_outline = outline;
  assign inner   = 1'b0;
  assign inner_n = 1'b0;
`endif

  // Inner outline rows jump straight from the left border column to the right one.
  always_comb begin
    last  = (row == max_y_q) && (col == cmax_q);
    row_n = row;
    col_n = col + 12'd1;
    if (col == cmax_q) begin
      row_n = row + 12'd1;
      col_n = cmin_q;
    end else if (inner) begin
      col_n = cmax_q;
    end
  end

  always_comb begin
    mask_ld_w = lane_mask(cmin_ld, min_x, max_x, PIX_PER_WORD);
    mask_n_w  = lane_mask(col_n, min_x_q, max_x_q, PIX_PER_WORD);
    if (inner_n) mask_n_w = edge_mask(col_n, min_x_q, max_x_q, PIX_PER_WORD);
  end

  assign last_accept = en_wr && ready && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row     <= '0;
      col     <= '0;
      cmin_q  <= '0;
      cmax_q  <= '0;
      min_x_q <= '0;
      max_x_q <= '0;
      max_y_q <= '0;
      en_wr   <= 1'b0;
      wrea    <= '0;
      addr    <= '0;
      data    <= '0;
    end else if (load) begin
      row     <= min_y;
      col     <= cmin_ld;
      cmin_q  <= cmin_ld;
      cmax_q  <= cmax_ld;
      min_x_q <= min_x;
      max_x_q <= max_x;
      max_y_q <= max_y;
      en_wr   <= 1'b1;
      wrea    <= mask_ld_w[PIX_PER_WORD-1:0];
      addr    <= word_addr(min_y, cmin_ld);
      data    <= FBUF_DATA_WIDTH'({PIX_PER_WORD{color}});
    end else if (en_wr && ready) begin
      if (last) begin
        en_wr <= 1'b0;
      end else begin
        row  <= row_n;
        col  <= col_n;
        wrea <= mask_n_w[PIX_PER_WORD-1:0];
        addr <= word_addr(row_n, col_n);
      end
    end
  end

endmodule

// File: rtl/axi4_lite_gpu_rect_raster.sv
// Rectangle rasteriser: latches corner/color operands, validates them and streams
// packed framebuffer write beats. Outline mode requires GPU_RECT_OUTLINE_EN.
module axi4_lite_gpu_rect_raster
  import gpu_rect_pkg::*;
#(
  parameter int FRAME_WIDTH_SCALED  = 640,
  parameter int FRAME_HEIGHT_SCALED = 480,
  parameter int COLOR_WIDTH         = 8,
  parameter int PIX_PER_WORD        = 4,
  parameter int FBUF_ADDR_WIDTH     = 17,
  parameter int FBUF_DATA_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  input  logic                       left_valid,
  input  logic [11:0]                left_x,
  input  logic [11:0]                left_y,
  input  logic                       right_valid,
  input  logic [11:0]                right_x,
  input  logic [11:0]                right_y,
  input  logic                       color_valid,
  input  logic [COLOR_WIDTH-1:0]     color,
  input  logic                       mode,
  output logic                       fbuf_en_wr,
  output logic [PIX_PER_WORD-1:0]    fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
  input  logic                       fbuf_ready
);

  // state | meaning
  // IDLE  | collecting operands, waiting for start
  // BUSY  | streaming write beats
  // DONE  | one-cycle completion pulse, operands cleared
  // ERR   | one-cycle error pulse, operands cleared

  localparam coord_t W_C = coord_t'(FRAME_WIDTH_SCALED);
  localparam coord_t H_C = coord_t'(FRAME_HEIGHT_SCALED);

  state_e state;
  coord_t lx, ly, rx, ry;
  logic [COLOR_WIDTH-1:0] color_q;
  logic   l_ok, r_ok, c_ok;
  logic   bad_coord, ops_ok, load, last_accept;
  coord_t min_x, max_x, min_y, max_y;

  assign bad_coord = (left_valid  && (left_x  >= W_C || left_y  >= H_C)) ||
                     (right_valid && (right_x >= W_C || right_y >= H_C));
  assign ops_ok = l_ok && r_ok && c_ok;
  assign load   = (state == IDLE) && !bad_coord && start && ops_ok;

  assign min_x = (lx < rx) ? lx : rx;
  assign max_x = (lx < rx) ? rx : lx;
  assign min_y = (ly < ry) ? ly : ry;
  assign max_y = (ly < ry) ? ry : ly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      lx      <= '0;
      ly      <= '0;
      rx      <= '0;
      ry      <= '0;
      color_q <= '0;
      l_ok    <= 1'b0;
      r_ok    <= 1'b0;
      c_ok    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (left_valid) begin
            lx   <= left_x;
            ly   <= left_y;
            l_ok <= 1'b1;
          end
          if (right_valid) begin
            rx   <= right_x;
            ry   <= right_y;
            r_ok <= 1'b1;
          end
          if (color_valid) begin
            color_q <= color;
            c_ok    <= 1'b1;
          end
          // A bad coordinate wins over a simultaneous start.
          if (bad_coord) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (start) begin
            if (ops_ok) begin
              state <= BUSY;
              busy  <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (last_accept) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE, ERR: begin
          state   <= IDLE;
          done    <= 1'b0;
          err     <= 1'b0;
          lx      <= '0;
          ly      <= '0;
          rx      <= '0;
          ry      <= '0;
          color_q <= '0;
          l_ok    <= 1'b0;
          r_ok    <= 1'b0;
          c_ok    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  gpu_rect_span_gen #(
    .FRAME_WIDTH_SCALED (FRAME_WIDTH_SCALED),
    .COLOR_WIDTH        (COLOR_WIDTH),
    .PIX_PER_WORD       (PIX_PER_WORD),
    .FBUF_ADDR_WIDTH    (FBUF_ADDR_WIDTH),
    .FBUF_DATA_WIDTH    (FBUF_DATA_WIDTH)
  ) u_span (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .outline     (mode),
    .min_x       (min_x),
    .max_x       (max_x),
    .min_y       (min_y),
    .max_y       (max_y),
    .color       (color_q),
    .ready       (fbuf_ready),
    .en_wr       (fbuf_en_wr),
    .wrea        (fbuf_wrea),
    .addr        (fbuf_addr),
    .data        (fbuf_data),
    .last_accept (last_accept)
  );

endmodule
